ula_raster_gen: RTL
===================

Name: ula_raster_gen

Overview:
- Parametrised raster timing generator for the Spectrum video path.
- Provides horizontal/vertical counters, sync/blank, border flag, flash phase and the frame interrupt for three ULA timing profiles: Pentagon, 48K and 128K.
- Adds a programmable raster-line interrupt with acknowledge, and a programmable interrupt pulse length.
- Feeds the pixel fetch/shift logic, the CPU contention logic and the video mixer.

Parameters:
- HCW, 9, width of hc.
- VCW, 9, width of vc.
- INTW, 6, width of interrupt pulse-length counter.
- FLW, 5, width of frame flash counter.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high.
- ce_7mp  in  1  pixel-clock enable, positive phase; advances counters.
- ce_7mn  in  1  pixel-clock enable, negative phase; updates sync/blank/int.
- mode  in  2  0=Pentagon, 1=48K, 2=128K, 3=treated as 48K.
- wide  in  1  extended visible area.
- int_len  in  INTW  frame/line INT pulse length in ce_7mn ticks; 0 disables both.
- line_int_ena  in  1  enable raster-line interrupt.
- line_int_line  in  VCW  line number for the raster interrupt.
- line_int_ack  in  1  clears line_int_flag.
- hc  out  HCW  horizontal counter.
- vc  out  VCW  vertical counter.
- hblank, vblank, hsync, vsync  out  1 each  raster controls.
- border  out  1  outside 256x192 area.
- flash  out  1  flash phase (MSB of frame counter).
- frame_start  out  1  one-clk pulse on vc wrap.
- n_int  out  1  CPU interrupt, active low.
- line_int_flag  out  1  sticky raster-interrupt status.

Behaviour:

Reset values:
- hc=0, vc=0, hblank=1, vblank=1, hsync=0, vsync=0, flash counter=0, frame_start=0, n_int=1, line_int_flag=0.
- Pulse counters idle.

Counters (ce_7mp):
- HMAX=455 for 128K, otherwise 447. VMAX: Pentagon 319, 48K 311, 128K 310.
- If hc>=HMAX: hc<=0; else hc+1.
- On hc wrap: if vc>=VMAX, vc<=0, flash counter +1 (wraps mod 2^FLW), frame_start pulses for 1 clk_sys; else vc+1.
- The >= comparison means a mode switch mid-line or mid-frame wraps on the next tick with no lock-up.

Horizontal sync/blank (ce_7mn):
- Pentagon: hblank set at hc 312, cleared at 420; hsync set at 338, cleared at 370.
- 128K: hblank 312/424; hsync 340/372.
- 48K: hblank 300/428; hsync 336/368.
- wide=1 overrides hblank <= !(hc<312 || hc>=HMAX-32).
- An internal 1-tick strobe accompanies each hsync rising edge.

Vertical sync/blank (ce_7mn, only on the hsync strobe):
- Pentagon: vblank 236/272; vsync 248/256.
- 48K and 128K: vblank 236/264; vsync 240/244.
- wide=1 overrides vblank <= !(vc<193 || vc>=VMAX-4).

Border:
- Combinational: border = vc[8] | (vc[7]&vc[6]) | hc[8].

Frame INT trigger (ce_7mn):
- 48K: vc=248, hc=4. 128K: vc=248, hc=8. Pentagon: vc=239, hc=326.

Line INT trigger:
- line_int_ena=1, vc=line_int_line, hc=256 (start of right border), on ce_7mn.
- Sets line_int_flag. line_int_ack clears it. If set and ack occur in the same cycle, set wins.

Pulse stretcher (one per source):
- On trigger, load int_len. Decrement on each ce_7mn while non-zero; active while non-zero.
- A retrigger while active reloads the counter.
- int_len=0: no pulse, but line_int_flag still sets.
- n_int = ~(frame_active | line_active).

Simultaneous ce_7mp and ce_7mn in one cycle:
- ce_7mn logic uses pre-update hc/vc.

Reset mid-frame:
- All state returns to reset values on the next clk_sys edge, including any pulse in progress.

Decomposition:
- Package ula_timing_pkg holds:
  - enum ula_mode_t {MODE_PENT, MODE_48K, MODE_128K}.
  - The per-mode constants (HMAX, VMAX, hblank/hsync/vblank/vsync edges, INT hc/vc) as a function returning a struct.
- Sub-module ula_int_pulse (load, ce, len -> active), instantiated twice.

Test Plan:
1. mode=1, int_len=32, run one frame: vc wraps 311->0 and flash counter +1. n_int low exactly 32 ce_7mn ticks starting at vc=248, hc=4.
2. mode=0: hc period 448 and vc period 320 lines. vsync high for lines 248..255. INT starts at vc=239, hc=326.
3. mode=2 with mode switched to 0 at hc=450: hc wraps to 0 on the next ce_7mp. No counter exceeds 455.
4. line_int_ena=1, line_int_line=100, int_len=10: n_int low for 10 ticks from vc=100, hc=256 and line_int_flag=1. Asserting ack clears the flag. Ack in the same cycle as the trigger leaves the flag at 1.
5. wide=1, mode=1: hblank=0 for hc<312 and hc>=415. vblank=1 only for vc in 193..306.
6. Assert reset mid-INT-pulse at vc=150: next cycle hc=vc=0, n_int=1, hblank=vblank=1, line_int_flag=0.

Source files
------------

// File: rtl/ula_timing_pkg.sv
// ============================================================================
// ula_timing_pkg : ULA timing profiles (Pentagon / 48K / 128K)  | rev 1.0
// ============================================================================
`default_nettype none

package ula_timing_pkg;

  typedef enum logic [1:0] {
    MODE_PENT = 2'd0,
    MODE_48K  = 2'd1,
    MODE_128K = 2'd2
  } ula_mode_t;

  localparam int c_HC_LINE_INT = 256;
  localparam int c_HC_WIDE_L   = 312;
  localparam int c_HC_WIDE_R   = 32;
  localparam int c_VC_WIDE_T   = 193;
  localparam int c_VC_WIDE_B   = 4;

  typedef struct packed {
    int hmax;
    int vmax;
    int hblank_set;
    int hblank_clr;
    int hsync_set;
    int hsync_clr;
    int vblank_set;
    int vblank_clr;
    int vsync_set;
    int vsync_clr;
    int int_hc;
    int int_vc;
  } ula_timing_t;

  // Encoding 3 is not a real machine and falls back to the 48K profile.
  function automatic ula_timing_t get_timing(input logic [1:0] mode);
    ula_timing_t t;
    case (mode)
      MODE_PENT: t = '{hmax: 447, vmax: 319,
                       hblank_set: 312, hblank_clr: 420,
                       hsync_set: 338, hsync_clr: 370,
                       vblank_set: 236, vblank_clr: 272,
                       vsync_set: 248, vsync_clr: 256,
                       int_hc: 326, int_vc: 239};
      MODE_128K: t = '{hmax: 455, vmax: 310,
                       hblank_set: 312, hblank_clr: 424,
                       hsync_set: 340, hsync_clr: 372,
                       vblank_set: 236, vblank_clr: 264,
                       vsync_set: 240, vsync_clr: 244,
                       int_hc: 8, int_vc: 248};
      default:   t = '{hmax: 447, vmax: 311,
                       hblank_set: 300, hblank_clr: 428,
                       hsync_set: 336, hsync_clr: 368,
                       vblank_set: 236, vblank_clr: 264,
                       vsync_set: 240, vsync_clr: 244,
                       int_hc: 4, int_vc: 248};
    endcase
    return t;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ula_int_pulse.sv
// ============================================================================
// ula_int_pulse : retriggerable interrupt pulse stretcher      | rev 1.0
// ============================================================================
`default_nettype none

module ula_int_pulse #(
  parameter int INTW = 6
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            load,
  input  logic            ce,
  input  logic [INTW-1:0] len,
  output logic            active
);

  logic [INTW-1:0] r_cnt;

  always_ff @(posedge clk_sys) begin
    if (reset)
      r_cnt <= '0;
    else if (load)
      r_cnt <= len;
    else if (ce && (r_cnt != '0))
      r_cnt <= r_cnt - INTW'(1);
  end

  assign active = (r_cnt != '0);

endmodule

`default_nettype wire

// File: rtl/ula_raster_gen.sv
// ============================================================================
// ula_raster_gen : Spectrum raster counters, sync/blank, INT   | rev 1.0
// ============================================================================
`default_nettype none

module ula_raster_gen
  import ula_timing_pkg::*;
#(
  parameter int HCW  = 9,
  parameter int VCW  = 9,
  parameter int INTW = 6,
  parameter int FLW  = 5
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            ce_7mp,
  input  logic            ce_7mn,
  input  logic [1:0]      mode,
  input  logic            wide,
  input  logic [INTW-1:0] int_len,
  input  logic            line_int_ena,
  input  logic [VCW-1:0]  line_int_line,
  input  logic            line_int_ack,
  output logic [HCW-1:0]  hc,
  output logic [VCW-1:0]  vc,
  output logic            hblank,
  output logic            vblank,
  output logic            hsync,
  output logic            vsync,
  output logic            border,
  output logic            flash,
  output logic            frame_start,
  output logic            n_int,
  output logic            line_int_flag
);

  ula_timing_t    w_t;
  int             w_hc;
  int             w_vc;
  logic [HCW-1:0] r_hc;
  logic [VCW-1:0] r_vc;
  logic [FLW-1:0] r_flash_cnt;
  logic           r_frame_start;
  logic           r_hblank, r_vblank, r_hsync, r_vsync;
  logic           r_line_flag;
  logic           w_hs_strobe, w_frame_trig, w_line_trig;
  logic           w_frame_active, w_line_active;

  assign w_t  = get_timing(mode);
  assign w_hc = int'(r_hc);
  assign w_vc = int'(r_vc);

  // >= rather than == so a mode switch past the new limit still wraps.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hc          <= '0;
      r_vc          <= '0;
      r_flash_cnt   <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      if (ce_7mp) begin
        if (w_hc >= w_t.hmax) begin
          r_hc <= '0;
          if (w_vc >= w_t.vmax) begin
            r_vc          <= '0;
            r_flash_cnt   <= r_flash_cnt + FLW'(1);
            r_frame_start <= 1'b1;
          end else begin
            r_vc <= r_vc + VCW'(1);
          end
        end else begin
          r_hc <= r_hc + HCW'(1);
        end
      end
    end
  end

  assign w_hs_strobe = ce_7mn && (w_hc == w_t.hsync_set);

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_hblank <= 1'b1;
      r_vblank <= 1'b1;
      r_hsync  <= 1'b0;
      r_vsync  <= 1'b0;
    end else begin
      if (ce_7mn) begin
        if (wide)
          r_hblank <= !((w_hc < c_HC_WIDE_L) || (w_hc >= w_t.hmax - c_HC_WIDE_R));
        else if (w_hc == w_t.hblank_set)
          r_hblank <= 1'b1;
        else if (w_hc == w_t.hblank_clr)
          r_hblank <= 1'b0;

        if (w_hc == w_t.hsync_set)
          r_hsync <= 1'b1;
        else if (w_hc == w_t.hsync_clr)
          r_hsync <= 1'b0;
      end

      // Vertical state only moves once per line, on the hsync rising edge.
      if (w_hs_strobe) begin
        if (wide)
          r_vblank <= !((w_vc < c_VC_WIDE_T) || (w_vc >= w_t.vmax - c_VC_WIDE_B));
        else if (w_vc == w_t.vblank_set)
          r_vblank <= 1'b1;
        else if (w_vc == w_t.vblank_clr)
          r_vblank <= 1'b0;

        if (w_vc == w_t.vsync_set)
          r_vsync <= 1'b1;
        else if (w_vc == w_t.vsync_clr)
          r_vsync <= 1'b0;
      end
    end
  end

  assign w_frame_trig = ce_7mn && (w_vc == w_t.int_vc) && (w_hc == w_t.int_hc);
  assign w_line_trig  = ce_7mn && line_int_ena && (r_vc == line_int_line) &&
                        (w_hc == c_HC_LINE_INT);

  always_ff @(posedge clk_sys) begin
    if (reset)
      r_line_flag <= 1'b0;
    else if (w_line_trig)
      r_line_flag <= 1'b1;
    else if (line_int_ack)
      r_line_flag <= 1'b0;
  end

  ula_int_pulse #(.INTW(INTW)) u_frame_pulse (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load    (w_frame_trig),
    .ce      (ce_7mn),
    .len     (int_len),
    .active  (w_frame_active)
  );

  ula_int_pulse #(.INTW(INTW)) u_line_pulse (
    .clk_sys (clk_sys),
    .reset   (reset),
    .load    (w_line_trig),
    .ce      (ce_7mn),
    .len     (int_len),
    .active  (w_line_active)
  );

  assign hc            = r_hc;
  assign vc            = r_vc;
  assign hblank        = r_hblank;
  assign vblank        = r_vblank;
  assign hsync         = r_hsync;
  assign vsync         = r_vsync;
  assign border        = r_vc[8] | (r_vc[7] & r_vc[6]) | r_hc[8];
  assign flash         = r_flash_cnt[FLW-1];
  assign frame_start   = r_frame_start;
  assign n_int         = ~(w_frame_active | w_line_active);
  assign line_int_flag = r_line_flag;

endmodule

`default_nettype wire
